// File: rtl/postmortem_axi_writer.sv
// Single-beat AXI4 write master for the postmortem capture path: one 64-bit word per
// request, written to PS DDR through an HP/HPC slave port, completion signalled by o_done.
module postmortem_axi_writer #(
  parameter int unsigned SETTLE_CYC  = 2,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter logic [39:0] DDR_BASE    = 40'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [39:0] i_ddr_addr,
  input  logic [63:0] i_ddr_data,
  output logic        o_done,
  input  logic        i_clr_err,
  output logic        o_resp_err,
  output logic        o_timeout,
  output logic        o_align_err,
  output logic [31:0] o_wr_cnt,
  output logic [2:0]  o_state,
  output logic [39:0] m_axi_awaddr,
  output logic [7:0]  m_axi_awlen,
  output logic [2:0]  m_axi_awsize,
  output logic [1:0]  m_axi_awburst,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [63:0] m_axi_wdata,
  output logic [7:0]  m_axi_wstrb,
  output logic        m_axi_wlast,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready
);

  // Handshake rule for AW, W and B: a beat transfers on a rising edge where valid and
  // ready are both high; once raised, valid and its payload hold until that edge.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_XFER = 3'd2,
    S_RESP = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] TMO_MAX     = 16'(TIMEOUT_CYC);
  localparam logic [15:0] TMO_LAST    = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [7:0]  settle_cnt;
  logic [15:0] tmo_cnt;
  logic        aw_done, w_done;
  logic        sample;
  logic        aw_hs, w_hs, b_hs;
  logic        wait_st, tmo_hit;
  logic        resp_err_set, align_err_set;

  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'd3;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = 8'hFF;
  assign m_axi_wlast   = 1'b1;
  assign o_state       = state;

  assign aw_hs   = m_axi_awvalid & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready;
  assign b_hs    = m_axi_bvalid & m_axi_bready;
  assign wait_st = (state == S_XFER) || (state == S_RESP);

  always_comb begin
    state_nxt = state;
    sample    = 1'b0;
    case (state)
      S_IDLE: if (i_start) state_nxt = S_ARM;
      S_ARM: begin
        if (!i_start) begin
          state_nxt = S_IDLE;
        end else if (settle_cnt == SETTLE_LAST) begin
          sample    = 1'b1;
          state_nxt = S_XFER;
        end
      end
      // Both channels are tracked by registered flags, so either order completes.
      S_XFER: if (aw_done && w_done) state_nxt = S_RESP;
      S_RESP: if (b_hs) state_nxt = S_DONE;
      S_DONE: state_nxt = S_ARM;
      default: state_nxt = S_IDLE;
    endcase
  end

  // The wait counter restarts on every state change; a wait only counts while it lasts.
  assign tmo_hit       = wait_st && (state_nxt == state) && (tmo_cnt == TMO_LAST);
  assign resp_err_set  = b_hs && (m_axi_bresp != 2'b00);
  assign align_err_set = sample && (i_ddr_addr[2:0] != 3'b000);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      settle_cnt    <= '0;
      tmo_cnt       <= '0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      o_done        <= 1'b0;
      o_wr_cnt      <= '0;
      o_resp_err    <= 1'b0;
      o_timeout     <= 1'b0;
      o_align_err   <= 1'b0;
    end else begin
      if (state == S_ARM) settle_cnt <= settle_cnt + 8'd1;
      else                settle_cnt <= '0;

      if (state_nxt != state)                tmo_cnt <= '0;
      else if (wait_st && tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + 16'd1;

      if (sample) begin
        m_axi_awaddr  <= DDR_BASE + {i_ddr_addr[39:3], 3'b000};
        m_axi_wdata   <= i_ddr_data;
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        aw_done       <= 1'b0;
        w_done        <= 1'b0;
      end else begin
        if (aw_hs) begin
          m_axi_awvalid <= 1'b0;
          aw_done       <= 1'b1;
        end
        if (w_hs) begin
          m_axi_wvalid <= 1'b0;
          w_done       <= 1'b1;
        end
      end

      if (state == S_XFER && state_nxt == S_RESP) m_axi_bready <= 1'b1;
      else if (b_hs)                              m_axi_bready <= 1'b0;

      o_done <= (state_nxt == S_DONE);
      if (b_hs) o_wr_cnt <= o_wr_cnt + 32'd1;

      // A new error event outranks a clear issued in the same cycle.
      o_resp_err  <= resp_err_set  | (o_resp_err  & ~i_clr_err);
      o_timeout   <= tmo_hit       | (o_timeout   & ~i_clr_err);
      o_align_err <= align_err_set | (o_align_err & ~i_clr_err);
    end
  end

endmodule

// File: tb/tb_postmortem_axi_writer.sv
// Bench for postmortem_axi_writer: directed requests against a configurable AXI slave,
// AW/W/done traffic checked by a monitor against expected queues.
module tb_postmortem_axi_writer;

  localparam logic [39:0] BASE    = 40'h08_0000_0000;
  localparam logic [2:0]  ST_IDLE = 3'd0;
  localparam logic [2:0]  ST_XFER = 3'd2;
  localparam logic [2:0]  ST_RESP = 3'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        i_start, i_clr_err;
  logic [39:0] i_ddr_addr;
  logic [63:0] i_ddr_data;
  logic        o_done, o_resp_err, o_timeout, o_align_err;
  logic [31:0] o_wr_cnt;
  logic [2:0]  o_state;
  logic [39:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid, m_axi_awready;
  logic [63:0] m_axi_wdata;
  logic [7:0]  m_axi_wstrb;
  logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid, m_axi_bready;

  postmortem_axi_writer #(
    .SETTLE_CYC (2),
    .TIMEOUT_CYC(16),
    .DDR_BASE   (BASE)
  ) dut (
    .i_clk(clk), .i_rst(rst_n), .i_start(i_start),
    .i_ddr_addr(i_ddr_addr), .i_ddr_data(i_ddr_data), .o_done(o_done),
    .i_clr_err(i_clr_err), .o_resp_err(o_resp_err), .o_timeout(o_timeout),
    .o_align_err(o_align_err), .o_wr_cnt(o_wr_cnt), .o_state(o_state),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  // scoreboard state
  logic [39:0] exp_aw_q[$];
  logic [63:0] exp_w_q[$];
  logic [31:0] exp_cnt_q[$];
  logic [31:0] exp_cnt = '0;
  int pass_n = 0;
  int total_n = 0;

  // slave configuration and event counters
  int aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0] slv_bresp = 2'b00;
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, done_n = 0;
  int awv_rise_cyc = 0, done_cyc = 0;

  // request vector table
  logic [39:0] b_addr[5];
  logic [39:0] b_exp[5];
  logic [63:0] b_data[5];
  logic [1:0]  b_resp[5];
  logic        b_err[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total_n++;
    $display("FAIL %s: got no matching event, expected one within the cycle budget", name);
  endtask

  // AW / W ready generators: ready after the configured number of valid cycles
  initial begin
    int cnt;
    cnt = 0;
    m_axi_awready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_axi_awvalid) begin
        if (cnt >= aw_delay) m_axi_awready = 1'b1;
        else begin m_axi_awready = 1'b0; cnt++; end
      end else begin
        m_axi_awready = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    int cnt;
    cnt = 0;
    m_axi_wready = 1'b0;
    forever begin
      @(negedge clk);
      if (m_axi_wvalid) begin
        if (cnt >= w_delay) m_axi_wready = 1'b1;
        else begin m_axi_wready = 1'b0; cnt++; end
      end else begin
        m_axi_wready = 1'b0;
        cnt = 0;
      end
    end
  end

  // B generator: one response per completed AW+W pair, b_delay cycles later
  initial begin
    int cnt, issued, acked;
    cnt = 0; issued = 0; acked = 0;
    m_axi_bvalid = 1'b0;
    m_axi_bresp  = 2'b00;
    forever begin
      @(negedge clk);
      if (m_axi_bvalid && b_hs_n > acked) begin
        m_axi_bvalid = 1'b0;
        acked++;
      end
      if (!m_axi_bvalid && aw_hs_n > issued && w_hs_n > issued) begin
        if (cnt >= b_delay) begin
          m_axi_bvalid = 1'b1;
          m_axi_bresp  = slv_bresp;
          issued++;
          cnt = 0;
        end else cnt++;
      end
    end
  end

  // monitor: a beat seen with valid&ready here transfers on the next rising edge
  initial begin
    logic awv_prev;
    awv_prev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (m_axi_awvalid && !awv_prev) awv_rise_cyc = cyc;
        if (m_axi_awvalid && m_axi_awready) begin
          aw_hs_n++;
          if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
          else check("awaddr", 64'(m_axi_awaddr), 64'(exp_aw_q.pop_front()));
          check("awlen", 64'(m_axi_awlen), 64'd0);
          check("awsize", 64'(m_axi_awsize), 64'd3);
          check("awburst", 64'(m_axi_awburst), 64'd1);
        end
        if (m_axi_wvalid && m_axi_wready) begin
          w_hs_n++;
          if (exp_w_q.size() == 0) fail_now("w_unexpected");
          else check("wdata", m_axi_wdata, exp_w_q.pop_front());
          check("wstrb", 64'(m_axi_wstrb), 64'hFF);
          check("wlast", 64'(m_axi_wlast), 64'd1);
        end
        if (m_axi_bvalid && m_axi_bready) b_hs_n++;
        if (o_done) begin
          done_n++;
          done_cyc = cyc;
          if (exp_cnt_q.size() == 0) fail_now("done_unexpected");
          else check("wr_cnt_at_done", 64'(o_wr_cnt), 64'(exp_cnt_q.pop_front()));
        end
      end
      awv_prev = m_axi_awvalid;
    end
  end

  // driver tasks
  task automatic set_vec(input int k, input logic [39:0] a, input logic [39:0] e,
                         input logic [63:0] d, input logic [1:0] r, input logic err);
    b_addr[k] = a; b_exp[k] = e; b_data[k] = d; b_resp[k] = r; b_err[k] = err;
  endtask

  task automatic load_req(input int k);
    i_ddr_addr = b_addr[k];
    i_ddr_data = b_data[k];
    slv_bresp  = b_resp[k];
    exp_aw_q.push_back(b_exp[k]);
    exp_w_q.push_back(b_data[k]);
    exp_cnt = exp_cnt + 32'd1;
    exp_cnt_q.push_back(exp_cnt);
  endtask

  task automatic wait_done(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (done_n >= target) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("done_wait");
  endtask

  task automatic wait_whs(input int target);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (w_hs_n >= target) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("w_handshake_wait");
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (o_state == s) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now(name);
  endtask

  task automatic run_burst(input int n, input bit chk_lat);
    int base, st;
    base = done_n;
    st   = cyc;
    load_req(0);
    i_start = 1'b1;
    for (int k = 0; k < n; k++) begin
      wait_done(base + k + 1);
      if (chk_lat && k == 0) begin
        check("latency_valid", 64'(awv_rise_cyc - st), 64'd3);
        check("latency_done", 64'(done_cyc - st), 64'd6);
      end
      check("resp_err_at_done", 64'(o_resp_err), 64'(b_err[k]));
      if (k < n - 1) load_req(k + 1);
      else i_start = 1'b0;
    end
    wait_state(ST_IDLE, "idle_after_burst");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected one before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, a0, w0, b0;
    rst_n = 1'b0; i_start = 1'b0; i_clr_err = 1'b0;
    i_ddr_addr = '0; i_ddr_data = '0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_state", 64'(o_state), 64'd0);
    check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("rst_bready", 64'(m_axi_bready), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_wr_cnt", 64'(o_wr_cnt), 64'd0);
    check("rst_awaddr", 64'(m_axi_awaddr), 64'd0);
    check("rst_wdata", m_axi_wdata, 64'd0);
    check("rst_flags", 64'({o_resp_err, o_timeout, o_align_err}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #2;

    // 1: five back-to-back requests, zero-wait slave
    set_vec(0, 40'h00_0010_0000, 40'h08_0010_0000, 64'h1111_0000_AAAA_0001, 2'b00, 1'b0);
    set_vec(1, 40'h00_0020_0008, 40'h08_0020_0008, 64'h2222_0000_BBBB_0002, 2'b00, 1'b0);
    set_vec(2, 40'h00_0030_0010, 40'h08_0030_0010, 64'h3333_0000_CCCC_0003, 2'b00, 1'b0);
    set_vec(3, 40'h00_0040_0018, 40'h08_0040_0018, 64'h4444_0000_DDDD_0004, 2'b00, 1'b0);
    set_vec(4, 40'h00_0050_0020, 40'h08_0050_0020, 64'h5555_0000_EEEE_0005, 2'b00, 1'b0);
    run_burst(5, 1'b1);
    check("t1_wr_cnt", 64'(o_wr_cnt), 64'd5);
    check("t1_done_pulses", 64'(done_n), 64'd5);

    // 2: W accepted at once, AW held back
    aw_delay = 4;
    set_vec(0, 40'h00_0070_0100, 40'h08_0070_0100, 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0);
    d0 = done_n; a0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    load_req(0);
    i_start = 1'b1;
    wait_whs(w0 + 1);
    @(negedge clk); #2;
    check("t2_wvalid_dropped", 64'(m_axi_wvalid), 64'd0);
    check("t2_awvalid_held", 64'(m_axi_awvalid), 64'd1);
    check("t2_aw_pending", 64'(aw_hs_n - a0), 64'd0);
    wait_done(d0 + 1);
    i_start = 1'b0;
    check("t2_one_b", 64'(b_hs_n - b0), 64'd1);
    wait_state(ST_IDLE, "t2_idle");
    check("t2_wr_cnt", 64'(o_wr_cnt), 64'd6);
    aw_delay = 0;

    // 3: SLVERR on the third write, then clear; last vector wraps past 2^40
    set_vec(0, 40'h00_0600_0000, 40'h08_0600_0000, 64'hC0DE_0000_0000_0010, 2'b00, 1'b0);
    set_vec(1, 40'h00_0600_0040, 40'h08_0600_0040, 64'hC0DE_0000_0000_0011, 2'b00, 1'b0);
    set_vec(2, 40'h00_0600_0080, 40'h08_0600_0080, 64'hC0DE_0000_0000_0012, 2'b10, 1'b1);
    set_vec(3, 40'h00_0600_00C0, 40'h08_0600_00C0, 64'hC0DE_0000_0000_0013, 2'b00, 1'b1);
    set_vec(4, 40'hF8_0000_0008, 40'h00_0000_0008, 64'hC0DE_0000_0000_0014, 2'b00, 1'b1);
    run_burst(5, 1'b0);
    check("t3_wr_cnt", 64'(o_wr_cnt), 64'd11);
    i_clr_err = 1'b1;
    @(negedge clk); #2;
    i_clr_err = 1'b0;
    check("t3_resp_err_cleared", 64'(o_resp_err), 64'd0);

    // 6: misaligned address, clear held high across the sampling edge
    check("t6_align_before", 64'(o_align_err), 64'd0);
    set_vec(0, 40'h00_0010_0004, 40'h08_0010_0000, 64'hFEED_FACE_0000_0006, 2'b00, 1'b0);
    d0 = done_n;
    i_clr_err = 1'b1;
    load_req(0);
    i_start = 1'b1;
    wait_state(ST_XFER, "t6_xfer");
    check("t6_align_set_wins", 64'(o_align_err), 64'd1);
    i_clr_err = 1'b0;
    wait_done(d0 + 1);
    i_start = 1'b0;
    check("t6_align_sticky", 64'(o_align_err), 64'd1);
    wait_state(ST_IDLE, "t6_idle");
    check("t6_wr_cnt", 64'(o_wr_cnt), 64'd12);

    // 4: B delayed past the 16-cycle wait limit
    b_delay = 20;
    set_vec(0, 40'h01_2345_6788, 40'h09_2345_6788, 64'h7777_8888_9999_0004, 2'b00, 1'b0);
    d0 = done_n;
    load_req(0);
    i_start = 1'b1;
    wait_state(ST_RESP, "t4_resp");
    repeat (15) begin @(negedge clk); #2; end
    check("t4_timeout_after_15", 64'(o_timeout), 64'd0);
    @(negedge clk); #2;
    check("t4_timeout_after_16", 64'(o_timeout), 64'd1);
    wait_done(d0 + 1);
    i_start = 1'b0;
    check("t4_timeout_sticky", 64'(o_timeout), 64'd1);
    wait_state(ST_IDLE, "t4_idle");
    check("t4_wr_cnt", 64'(o_wr_cnt), 64'd13);
    b_delay = 0;

    // 5: reset in the middle of XFER
    aw_delay = 10; w_delay = 10;
    set_vec(0, 40'h00_0090_0000, 40'h08_0090_0000, 64'h5A5A_5A5A_0000_0005, 2'b00, 1'b0);
    load_req(0);
    i_start = 1'b1;
    wait_state(ST_XFER, "t5_xfer");
    i_start = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_awvalid", 64'(m_axi_awvalid), 64'd0);
    check("t5_wvalid", 64'(m_axi_wvalid), 64'd0);
    check("t5_bready", 64'(m_axi_bready), 64'd0);
    check("t5_done", 64'(o_done), 64'd0);
    check("t5_state", 64'(o_state), 64'd0);
    check("t5_wr_cnt", 64'(o_wr_cnt), 64'd0);
    check("t5_flags", 64'({o_resp_err, o_timeout, o_align_err}), 64'd0);
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_cnt_q.delete();
    exp_cnt = '0;
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #2;

    // counter restarts after reset
    set_vec(0, 40'h00_0000_0040, 40'h08_0000_0040, 64'hABCD_0000_0000_0001, 2'b00, 1'b0);
    run_burst(1, 1'b0);
    check("post_rst_wr_cnt", 64'(o_wr_cnt), 64'd1);

    check("aw_queue_drained", 64'(exp_aw_q.size()), 64'd0);
    check("w_queue_drained", 64'(exp_w_q.size()), 64'd0);
    check("done_queue_drained", 64'(exp_cnt_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
